// File: rtl/reg_op_sequencer_if.sv
// Command, register-bank and completion signals for reg_op_sequencer.
// The sequencer connects through the slave modport; the command source and bank use master.
interface reg_op_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [3:0]  cmd_dst;
  logic [3:0]  cmd_src;
  logic        cmd_size;
  logic        cmd_hl_dst;
  logic        cmd_hl_src;
  logic [15:0] cmd_imm;

  logic [3:0]  rf_reg_read1;
  logic [3:0]  rf_reg_read2;
  logic [15:0] rf_read_data1;
  logic [15:0] rf_read_data2;
  logic        rf_en_write;
  logic [3:0]  rf_reg_write;
  logic [15:0] rf_write_data;
  logic        rf_size;
  logic        rf_select_high_low;

  logic [15:0] result;
  logic        done;
  logic        err;

  modport slave (
    input  cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_size, cmd_hl_dst, cmd_hl_src, cmd_imm,
    input  rf_read_data1, rf_read_data2,
    output cmd_ready,
    output rf_reg_read1, rf_reg_read2, rf_en_write, rf_reg_write, rf_write_data,
    output rf_size, rf_select_high_low,
    output result, done, err
  );

  modport master (
    output cmd_valid, cmd_op, cmd_dst, cmd_src, cmd_size, cmd_hl_dst, cmd_hl_src, cmd_imm,
    output rf_read_data1, rf_read_data2,
    input  cmd_ready,
    input  rf_reg_read1, rf_reg_read2, rf_en_write, rf_reg_write, rf_write_data,
    input  rf_size, rf_select_high_low,
    input  result, done, err
  );
endinterface

// File: rtl/reg_op_sequencer.sv
// Register-operation sequencer: reads dst/src from the bank, computes MOV/MOVI/XCHG/ADD/INC/DEC,
// writes back (two writes for XCHG) and pulses done with result/err.
module reg_op_sequencer (
  input  logic              clk,
  input  logic              reset,
  reg_op_sequencer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, READ, WR1, WR2, FIN} state_e;
  typedef enum logic [2:0] {
    OP_MOV  = 3'b000,
    OP_MOVI = 3'b001,
    OP_XCHG = 3'b010,
    OP_ADD  = 3'b011,
    OP_INC  = 3'b100,
    OP_DEC  = 3'b101
  } op_e;

  state_e      state_q;
  logic [2:0]  op_q;
  logic [3:0]  dst_q;
  logic [3:0]  src_q;
  logic        size_q;
  logic        hl_dst_q;
  logic        hl_src_q;
  logic [15:0] imm_q;
  logic [15:0] old_q;
  logic [15:0] pend_q;

  logic        cmd_ready_q;
  logic [3:0]  rf_reg_read1_q;
  logic [3:0]  rf_reg_read2_q;
  logic        rf_en_write_q;
  logic [3:0]  rf_reg_write_q;
  logic [15:0] rf_write_data_q;
  logic        rf_size_q;
  logic        rf_sel_hl_q;
  logic [15:0] result_q;
  logic        done_q;
  logic        err_q;

  logic        uses_src;
  logic        cmd_illegal;
  logic [15:0] dst_opnd;
  logic [15:0] src_opnd;
  logic [15:0] alu_raw;
  logic [15:0] alu_res;

  always_comb begin
    uses_src    = (bus.cmd_op == OP_MOV) || (bus.cmd_op == OP_XCHG) || (bus.cmd_op == OP_ADD);
    cmd_illegal = (bus.cmd_op > 3'd5)
               || (bus.cmd_dst > 4'hD)
               || (uses_src && (bus.cmd_src > 4'hD))
               || (!bus.cmd_size && (bus.cmd_dst > 4'h3))
               || (!bus.cmd_size && uses_src && (bus.cmd_src > 4'h3));
  end

  // Byte operands are zero-extended so the 16-bit ALU result only needs truncating.
  always_comb begin
    dst_opnd = size_q ? bus.rf_read_data1
                      : {8'h00, (hl_dst_q ? bus.rf_read_data1[15:8] : bus.rf_read_data1[7:0])};
    src_opnd = size_q ? bus.rf_read_data2
                      : {8'h00, (hl_src_q ? bus.rf_read_data2[15:8] : bus.rf_read_data2[7:0])};
    case (op_q)
      OP_MOV, OP_XCHG: alu_raw = src_opnd;
      OP_MOVI:         alu_raw = imm_q;
      OP_ADD:          alu_raw = dst_opnd + src_opnd;
      OP_INC:          alu_raw = dst_opnd + 16'd1;
      OP_DEC:          alu_raw = dst_opnd - 16'd1;
      default:         alu_raw = '0;
    endcase
    alu_res = size_q ? alu_raw : {8'h00, alu_raw[7:0]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      op_q            <= '0;
      dst_q           <= '0;
      src_q           <= '0;
      size_q          <= 1'b0;
      hl_dst_q        <= 1'b0;
      hl_src_q        <= 1'b0;
      imm_q           <= '0;
      old_q           <= '0;
      pend_q          <= '0;
      cmd_ready_q     <= 1'b1;
      rf_reg_read1_q  <= '0;
      rf_reg_read2_q  <= '0;
      rf_en_write_q   <= 1'b0;
      rf_reg_write_q  <= '0;
      rf_write_data_q <= '0;
      rf_size_q       <= 1'b0;
      rf_sel_hl_q     <= 1'b0;
      result_q        <= '0;
      done_q          <= 1'b0;
      err_q           <= 1'b0;
    end else begin
      done_q          <= 1'b0;
      rf_en_write_q   <= 1'b0;
      rf_reg_read1_q  <= '0;
      rf_reg_read2_q  <= '0;
      rf_reg_write_q  <= '0;
      rf_write_data_q <= '0;
      rf_size_q       <= 1'b0;
      rf_sel_hl_q     <= 1'b0;

      case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            op_q        <= bus.cmd_op;
            dst_q       <= bus.cmd_dst;
            src_q       <= bus.cmd_src;
            size_q      <= bus.cmd_size;
            hl_dst_q    <= bus.cmd_hl_dst;
            hl_src_q    <= bus.cmd_hl_src;
            imm_q       <= bus.cmd_imm;
            cmd_ready_q <= 1'b0;
            if (cmd_illegal) begin
              state_q <= FIN;
              done_q  <= 1'b1;
              err_q   <= 1'b1;
            end else begin
              state_q        <= READ;
              err_q          <= 1'b0;
              rf_reg_read1_q <= bus.cmd_dst;
              rf_reg_read2_q <= bus.cmd_src;
            end
          end
        end

        READ: begin
          state_q         <= WR1;
          rf_en_write_q   <= 1'b1;
          rf_reg_write_q  <= dst_q;
          rf_write_data_q <= alu_res;
          rf_size_q       <= size_q;
          rf_sel_hl_q     <= size_q ? 1'b0 : hl_dst_q;
          pend_q          <= alu_res;
          old_q           <= dst_opnd;
        end

        WR1: begin
          if (op_q == OP_XCHG) begin
            state_q         <= WR2;
            rf_en_write_q   <= 1'b1;
            rf_reg_write_q  <= src_q;
            rf_write_data_q <= old_q;
            rf_size_q       <= size_q;
            rf_sel_hl_q     <= size_q ? 1'b0 : hl_src_q;
          end else begin
            state_q  <= FIN;
            done_q   <= 1'b1;
            result_q <= pend_q;
          end
        end

        WR2: begin
          state_q  <= FIN;
          done_q   <= 1'b1;
          result_q <= pend_q;
        end

        FIN: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
        end

        default: begin
          state_q     <= IDLE;
          cmd_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.cmd_ready          = cmd_ready_q;
  assign bus.rf_reg_read1       = rf_reg_read1_q;
  assign bus.rf_reg_read2       = rf_reg_read2_q;
  assign bus.rf_en_write        = rf_en_write_q;
  assign bus.rf_reg_write       = rf_reg_write_q;
  assign bus.rf_write_data      = rf_write_data_q;
  assign bus.rf_size            = rf_size_q;
  assign bus.rf_select_high_low = rf_sel_hl_q;
  assign bus.result             = result_q;
  assign bus.done               = done_q;
  assign bus.err                = err_q;

endmodule

// File: tb/tb_reg_op_sequencer.sv
// Bench for reg_op_sequencer: register-bank model, directed vector table, hand-written
// corner sequences and random commands checked against a behavioural model.
module tb_reg_op_sequencer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  reg_op_sequencer_if bus ();

  reg_op_sequencer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct packed {
    logic [3:0]  idx;
    logic [15:0] data;
    logic        size;
    logic        hl;
  } wr_t;

  int n_pass = 0;
  int n_chk  = 0;
  int cyc    = 0;

  logic [15:0] bank [16];
  logic [15:0] mdl  [16];
  logic [15:0] last_res = 16'h0000;
  logic        pre_en = 1'b0;
  logic [3:0]  pre_idx = 4'h0;
  logic [15:0] pre_val = 16'h0000;
  wr_t         got_wq [$];
  int          got_cyc [$];
  wr_t         exp_wq [$];

  function automatic logic [15:0] merge(logic [15:0] cur, logic [15:0] v, logic size, logic hl);
    if (size) return v;
    if (hl) return {v[7:0], cur[7:0]};
    return {cur[15:8], v[7:0]};
  endfunction

  assign bus.rf_read_data1 = bank[bus.rf_reg_read1];
  assign bus.rf_read_data2 = bank[bus.rf_reg_read2];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pre_en) bank[pre_idx] <= pre_val;
    if (bus.rf_en_write) begin
      got_wq.push_back(wr_t'{bus.rf_reg_write, bus.rf_write_data, bus.rf_size, bus.rf_select_high_low});
      got_cyc.push_back(cyc);
      bank[bus.rf_reg_write] <= merge(bank[bus.rf_reg_write], bus.rf_write_data,
                                      bus.rf_size, bus.rf_select_high_low);
    end
  end

  function automatic void chk(string nm, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endfunction

  // Reference model: architectural effect of one command on the register file.
  function automatic logic [15:0] mget(logic [3:0] i, logic size, logic hl);
    if (size) return mdl[i];
    return hl ? {8'h00, mdl[i][15:8]} : {8'h00, mdl[i][7:0]};
  endfunction

  task automatic model_cmd(input logic [2:0] op, input logic [3:0] dst, input logic [3:0] src,
                           input logic size, input logic hld, input logic hls, input logic [15:0] imm,
                           output logic e, output int lat, output logic [15:0] res);
    logic [15:0] a, b, r;
    logic        usesrc;
    int          m;
    usesrc = (op == 3'd0) || (op == 3'd2) || (op == 3'd3);
    e = (op > 3'd5) || (dst > 4'd13) || (usesrc && src > 4'd13)
        || (!size && (dst > 4'd3 || (usesrc && src > 4'd3)));
    exp_wq.delete();
    if (e) begin
      lat = 1;
      res = last_res;
      return;
    end
    m = size ? 65536 : 256;
    a = mget(dst, size, hld);
    b = mget(src, size, hls);
    case (op)
      3'd1:    r = size ? imm : {8'h00, imm[7:0]};
      3'd3:    r = 16'((int'(a) + int'(b)) % m);
      3'd4:    r = 16'((int'(a) + 1) % m);
      3'd5:    r = 16'((int'(a) + m - 1) % m);
      default: r = b;
    endcase
    exp_wq.push_back(wr_t'{dst, r, size, size ? 1'b0 : hld});
    mdl[dst] = merge(mdl[dst], r, size, hld);
    if (op == 3'd2) begin
      exp_wq.push_back(wr_t'{src, a, size, size ? 1'b0 : hls});
      mdl[src] = merge(mdl[src], a, size, hls);
      lat = 4;
    end else begin
      lat = 3;
    end
    last_res = r;
    res = r;
  endtask

  task automatic setreg(input logic [3:0] i, input logic [15:0] v);
    pre_en  = 1'b1;
    pre_idx = i;
    pre_val = v;
    mdl[i]  = v;
    @(negedge clk);
    pre_en  = 1'b0;
  endtask

  task automatic drive(input logic [2:0] op, input logic [3:0] dst, input logic [3:0] src,
                       input logic size, input logic hld, input logic hls, input logic [15:0] imm);
    bus.cmd_op     = op;
    bus.cmd_dst    = dst;
    bus.cmd_src    = src;
    bus.cmd_size   = size;
    bus.cmd_hl_dst = hld;
    bus.cmd_hl_src = hls;
    bus.cmd_imm    = imm;
  endtask

  task automatic scramble_cmd();
    drive(3'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
          16'($urandom));
  endtask

  task automatic wait_ready(input string nm);
    int n;
    n = 0;
    while (!bus.cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 32'(bus.cmd_ready), 32'd1);
  endtask

  task automatic check_bank(input string nm);
    logic [15:0] gv, ev;
    bit          found;
    gv = bank[0];
    ev = mdl[0];
    found = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (!found && bank[i] !== mdl[i]) begin
        gv = bank[i];
        ev = mdl[i];
        found = 1'b1;
      end
    end
    chk(nm, 32'(gv), 32'(ev));
  endtask

  task automatic check_writes(input string nm);
    chk({nm, "_nwr"}, 32'(got_wq.size()), 32'(exp_wq.size()));
    for (int i = 0; i < got_wq.size() && i < exp_wq.size(); i++)
      chk({nm, "_wr"}, 32'(got_wq[i]), 32'(exp_wq[i]));
  endtask

  task automatic run_cmd(input logic [2:0] op, input logic [3:0] dst, input logic [3:0] src,
                         input logic size, input logic hld, input logic hls, input logic [15:0] imm,
                         output logic g_err, output int g_lat, output logic [15:0] g_res);
    logic        e_err;
    int          e_lat;
    logic [15:0] e_res;
    model_cmd(op, dst, src, size, hld, hls, imm, e_err, e_lat, e_res);
    got_wq.delete();
    drive(op, dst, src, size, hld, hls, imm);
    bus.cmd_valid = 1'b1;
    wait_ready("accept_ready");
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    scramble_cmd();
    g_lat = 1;
    while (!bus.done && g_lat < 20) begin
      @(negedge clk);
      g_lat++;
    end
    g_err = bus.err;
    g_res = bus.result;
    chk("latency", 32'(g_lat), 32'(e_lat));
    chk("err", 32'(g_err), 32'(e_err));
    chk("result", 32'(g_res), 32'(e_res));
    check_writes("cmd");
    @(negedge clk);
    chk("done_pulse", 32'(bus.done), 32'd0);
    chk("ready_after", 32'(bus.cmd_ready), 32'd1);
    chk("idle_rf_zero", 32'({bus.rf_reg_read1, bus.rf_reg_read2, bus.rf_reg_write, bus.rf_write_data}), 32'd0);
    check_bank("bank");
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [3:0]  dst, src;
    logic        size, hld, hls;
    logic [15:0] imm;
    logic [3:0]  p1i;  logic [15:0] p1v;
    logic [3:0]  p2i;  logic [15:0] p2v;
    logic        e_err;
    int          e_lat;
    logic        chk_res;
    logic [15:0] e_res;
    logic [3:0]  c1i;  logic [15:0] c1v;
    logic [3:0]  c2i;  logic [15:0] c2v;
  } vec_t;

  initial begin
    #1000000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

  initial begin
    vec_t        vecs [13];
    logic        g_err;
    int          g_lat;
    logic [15:0] g_res;
    logic        e_err;
    int          e_lat;
    logic [15:0] e_res_a, e_res_b;
    wr_t         all_exp [$];
    int          n;
    logic [15:0] res_a;
    logic        saw;

    //         op    dst   src   sz hd hs imm       p1i   p1v       p2i   p2v       er lat cr e_res     c1i   c1v       c2i   c2v
    vecs[0]  = '{3'd3, 4'd0, 4'd1, 1, 0, 0, 16'h0000, 4'd0, 16'h1234, 4'd1, 16'h00FF, 0, 3, 1, 16'h1333, 4'd0, 16'h1333, 4'd1, 16'h00FF};
    vecs[1]  = '{3'd2, 4'd2, 4'd3, 0, 1, 0, 16'h0000, 4'd2, 16'hABCD, 4'd3, 16'h0011, 0, 4, 1, 16'h0011, 4'd2, 16'h11CD, 4'd3, 16'h00AB};
    vecs[2]  = '{3'd4, 4'd4, 4'd0, 1, 0, 0, 16'h0000, 4'd4, 16'hFFFF, 4'd4, 16'hFFFF, 0, 3, 1, 16'h0000, 4'd4, 16'h0000, 4'd4, 16'h0000};
    vecs[3]  = '{3'd5, 4'd3, 4'd0, 0, 0, 0, 16'h0000, 4'd3, 16'h5600, 4'd3, 16'h5600, 0, 3, 1, 16'h00FF, 4'd3, 16'h56FF, 4'd3, 16'h56FF};
    vecs[4]  = '{3'd0, 4'd5, 4'd0, 0, 0, 0, 16'h0000, 4'd5, 16'h4242, 4'd5, 16'h4242, 1, 1, 0, 16'h0000, 4'd5, 16'h4242, 4'd5, 16'h4242};
    vecs[5]  = '{3'd7, 4'd0, 4'd1, 1, 0, 0, 16'h0000, 4'd0, 16'h1111, 4'd1, 16'h2222, 1, 1, 0, 16'h0000, 4'd0, 16'h1111, 4'd1, 16'h2222};
    vecs[6]  = '{3'd1, 4'd13,4'd0, 1, 0, 0, 16'hBEEF, 4'd13,16'h0000, 4'd13,16'h0000, 0, 3, 1, 16'hBEEF, 4'd13,16'hBEEF, 4'd13,16'hBEEF};
    vecs[7]  = '{3'd0, 4'd2, 4'd14,1, 0, 0, 16'h0000, 4'd2, 16'h0F0F, 4'd2, 16'h0F0F, 1, 1, 0, 16'h0000, 4'd2, 16'h0F0F, 4'd2, 16'h0F0F};
    vecs[8]  = '{3'd1, 4'd0, 4'd0, 0, 1, 0, 16'h12AB, 4'd0, 16'h1234, 4'd0, 16'h1234, 0, 3, 1, 16'h00AB, 4'd0, 16'hAB34, 4'd0, 16'hAB34};
    vecs[9]  = '{3'd4, 4'd1, 4'd15,0, 1, 0, 16'h0000, 4'd1, 16'hFF00, 4'd1, 16'hFF00, 0, 3, 1, 16'h0000, 4'd1, 16'h0000, 4'd1, 16'h0000};
    vecs[10] = '{3'd2, 4'd5, 4'd5, 1, 0, 0, 16'h0000, 4'd5, 16'h7777, 4'd5, 16'h7777, 0, 4, 1, 16'h7777, 4'd5, 16'h7777, 4'd5, 16'h7777};
    vecs[11] = '{3'd3, 4'd0, 4'd1, 0, 0, 1, 16'h0000, 4'd0, 16'h00F0, 4'd1, 16'h2000, 0, 3, 1, 16'h0010, 4'd0, 16'h0010, 4'd1, 16'h2000};
    vecs[12] = '{3'd3, 4'd6, 4'd7, 1, 0, 0, 16'h0000, 4'd6, 16'hFFFF, 4'd7, 16'h0002, 0, 3, 1, 16'h0001, 4'd6, 16'h0001, 4'd7, 16'h0002};

    reset = 1'b1;
    bus.cmd_valid = 1'b0;
    drive(3'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 16'h0000);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", 32'(bus.cmd_ready), 32'd1);
    chk("rst_done_err", 32'({bus.done, bus.err}), 32'd0);
    chk("rst_result", 32'(bus.result), 32'h0);
    chk("rst_rf", 32'({bus.rf_en_write, bus.rf_size, bus.rf_select_high_low, bus.rf_reg_read1,
                       bus.rf_reg_read2, bus.rf_reg_write, bus.rf_write_data}), 32'd0);

    for (int i = 0; i < 16; i++) setreg(4'(i), 16'($urandom));

    for (int i = 0; i < 13; i++) begin
      setreg(vecs[i].p1i, vecs[i].p1v);
      setreg(vecs[i].p2i, vecs[i].p2v);
      run_cmd(vecs[i].op, vecs[i].dst, vecs[i].src, vecs[i].size, vecs[i].hld, vecs[i].hls,
              vecs[i].imm, g_err, g_lat, g_res);
      chk($sformatf("vec%0d_err", i), 32'(g_err), 32'(vecs[i].e_err));
      chk($sformatf("vec%0d_lat", i), 32'(g_lat), 32'(vecs[i].e_lat));
      if (vecs[i].chk_res) chk($sformatf("vec%0d_res", i), 32'(g_res), 32'(vecs[i].e_res));
      chk($sformatf("vec%0d_reg_a", i), 32'(bank[vecs[i].c1i]), 32'(vecs[i].c1v));
      chk($sformatf("vec%0d_reg_b", i), 32'(bank[vecs[i].c2i]), 32'(vecs[i].c2v));
    end

    // Back-to-back with valid held high; cmd fields change while the first command is in flight.
    setreg(4'd0, 16'h1000);
    setreg(4'd1, 16'h0234);
    setreg(4'd6, 16'h5555);
    model_cmd(3'd3, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0, 16'h0000, e_err, e_lat, e_res_a);
    all_exp.delete();
    foreach (exp_wq[i]) all_exp.push_back(exp_wq[i]);
    model_cmd(3'd1, 4'd6, 4'd0, 1'b1, 1'b0, 1'b0, 16'hC0DE, e_err, e_lat, e_res_b);
    foreach (exp_wq[i]) all_exp.push_back(exp_wq[i]);
    got_wq.delete();
    got_cyc.delete();
    drive(3'd3, 4'd0, 4'd1, 1'b1, 1'b0, 1'b0, 16'h0000);
    bus.cmd_valid = 1'b1;
    wait_ready("b2b_accept_a");
    @(posedge clk);
    @(negedge clk);
    drive(3'd1, 4'd6, 4'd0, 1'b1, 1'b0, 1'b0, 16'hC0DE);
    n = 0;
    res_a = 16'h0000;
    while (!bus.cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
      if (bus.done) res_a = bus.result;
    end
    chk("b2b_gap", 32'(n), 32'd3);
    chk("b2b_res_a", 32'(res_a), 32'(e_res_a));
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    g_lat = 1;
    while (!bus.done && g_lat < 20) begin
      @(negedge clk);
      g_lat++;
    end
    chk("b2b_lat_b", 32'(g_lat), 32'd3);
    chk("b2b_res_b", 32'(bus.result), 32'(e_res_b));
    @(negedge clk);
    exp_wq.delete();
    foreach (all_exp[i]) exp_wq.push_back(all_exp[i]);
    check_writes("b2b");
    if (got_cyc.size() == 2) chk("b2b_write_spacing", 32'(got_cyc[1] - got_cyc[0]), 32'd4);
    else chk("b2b_write_stamps", 32'(got_cyc.size()), 32'd2);
    check_bank("b2b_bank");

    // Reset while the first XCHG write is on the bus: neither write may land.
    setreg(4'd2, 16'hABCD);
    setreg(4'd3, 16'h0011);
    got_wq.delete();
    drive(3'd2, 4'd2, 4'd3, 1'b0, 1'b1, 1'b0, 16'h0000);
    bus.cmd_valid = 1'b1;
    wait_ready("rstx_accept");
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    chk("rstx_wr1_en", 32'(bus.rf_en_write), 32'd1);
    reset = 1'b1;
    #1;
    chk("rstx_en", 32'(bus.rf_en_write), 32'd0);
    chk("rstx_done_err", 32'({bus.done, bus.err}), 32'd0);
    chk("rstx_result", 32'(bus.result), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    last_res = 16'h0000;
    saw = 1'b0;
    @(negedge clk);
    chk("rstx_ready", 32'(bus.cmd_ready), 32'd1);
    saw = bus.done;
    repeat (4) begin
      @(negedge clk);
      saw = saw | bus.done;
    end
    chk("rstx_no_done", 32'(saw), 32'd0);
    chk("rstx_no_writes", 32'(got_wq.size()), 32'd0);
    check_bank("rstx_bank");

    for (int k = 0; k < 60; k++) begin
      logic [2:0]  op;
      logic [3:0]  dst, src;
      logic        size;
      op   = 3'($urandom_range(0, 7));
      size = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 4) == 0) dst = 4'($urandom_range(0, 15));
      else dst = size ? 4'($urandom_range(0, 13)) : 4'($urandom_range(0, 3));
      if ($urandom_range(0, 4) == 0) src = 4'($urandom_range(0, 15));
      else src = size ? 4'($urandom_range(0, 13)) : 4'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) setreg(4'($urandom_range(0, 13)), 16'($urandom));
      run_cmd(op, dst, src, size, 1'($urandom), 1'($urandom), 16'($urandom), g_err, g_lat, g_res);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
